// File: rtl/parking_ledger_if.sv
// Fee report handshake between the parking ledger and billing/display.
// master: drives valid + report fields, receives ready; slave: reverse.
interface parking_ledger_if;
  logic        fee_valid;
  logic        fee_ready;
  logic [3:0]  fee_car;
  logic [15:0] fee_time;
  logic [15:0] fee_amount;

  modport master (
    output fee_valid,
    output fee_car,
    output fee_time,
    output fee_amount,
    input  fee_ready
  );

  modport slave (
    input  fee_valid,
    input  fee_car,
    input  fee_time,
    input  fee_amount,
    output fee_ready
  );
endinterface

// File: rtl/parking_ledger.sv
// Parking ledger: slot occupancy, per-slot dwell timers, fee reports.
// Ports: clk, rst (sync, active-low), car_nb/enter/exit events,
// occupied/free_cnt/full status, err_dup/err_ghost/fifo_ovf pulses,
// fee: report stream (valid/ready) via parking_ledger_if.master.
module parking_ledger #(
  parameter int TICK_DIV = 100000000,
  parameter int RATE     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  car_nb,
  input  logic        enter,
  input  logic        exit,
  output logic [15:0] occupied,
  output logic [4:0]  free_cnt,
  output logic        full,
  output logic        err_dup,
  output logic        err_ghost,
  output logic        fifo_ovf,
  parking_ledger_if.master fee
);

  localparam int PW = $clog2(TICK_DIV);

  typedef struct packed {
    logic [3:0]  car;
    logic [15:0] tim;
    logic [15:0] amt;
  } rep_t;

  // prescaler
  logic [PW-1:0] pre_q, pre_d;
  logic          tick;

  assign tick  = (pre_q == PW'(TICK_DIV - 1));
  assign pre_d = tick ? '0 : pre_q + 1'b1;

  // occupancy and events
  logic [15:0] occ_q, occ_d;
  logic        slot_occ;
  logic        ev_in, ev_out;
  logic        dup_d, ghost_d;
  logic        dup_q, ghost_q;

  assign slot_occ = occ_q[car_nb];
  assign ev_in    = enter && !exit && !slot_occ;
  assign ev_out   = exit && !enter && slot_occ;
  assign dup_d    = enter && (exit || slot_occ);
  assign ghost_d  = exit && !enter && !slot_occ;

  always_comb begin
    occ_d = occ_q;
    if (ev_in)  occ_d[car_nb] = 1'b1;
    if (ev_out) occ_d[car_nb] = 1'b0;
  end

  // dwell counters; a clear on enter wins over a coincident tick
  logic [15:0] dw_q [16];
  logic [15:0] dw_d [16];

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      dw_d[i] = dw_q[i];
      if (ev_in && car_nb == 4'(i))
        dw_d[i] = '0;
      else if (tick && occ_q[i] && dw_q[i] != 16'hFFFF)
        dw_d[i] = dw_q[i] + 16'd1;
    end
  end

  // stage register: counter value before this edge's tick
  logic        stg_vld_q, stg_vld_d;
  logic [3:0]  stg_car_q, stg_car_d;
  logic [15:0] stg_tim_q, stg_tim_d;

  assign stg_vld_d = ev_out;
  assign stg_car_d = ev_out ? car_nb : stg_car_q;
  assign stg_tim_d = ev_out ? dw_q[car_nb] : stg_tim_q;

  // fee: 16x8 product fits 24 bits, then saturate
  logic [23:0] prod;
  logic [15:0] fee_amt;
  rep_t        rep;

  assign prod    = 24'(stg_tim_q) * 24'(RATE);
  assign fee_amt = (|prod[23:16]) ? 16'hFFFF : prod[15:0];
  assign rep     = '{car: stg_car_q, tim: stg_tim_q, amt: fee_amt};

  // report fifo
  rep_t       mem_q [4];
  logic [1:0] rd_q, rd_d;
  logic [1:0] wr_q, wr_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] rem;
  logic       vld, ffull;
  logic       pop, push, ovf_d, ovf_q;
  rep_t       head_q, head_d;

  assign vld   = (cnt_q != 3'd0);
  assign ffull = cnt_q[2];
  assign pop   = vld && fee.fee_ready;
  assign push  = stg_vld_q && (!ffull || pop);
  assign ovf_d = stg_vld_q && ffull && !pop;
  assign cnt_d = cnt_q + 3'(push) - 3'(pop);
  assign rd_d  = rd_q + 2'(pop);
  assign wr_d  = wr_q + 2'(push);
  assign rem   = cnt_q - 3'(pop);

  // head is a register so it holds its last value once empty
  always_comb begin
    head_d = head_q;
    if (rem != 3'd0)
      head_d = mem_q[rd_d];
    else if (push)
      head_d = rep;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_q     <= '0;
      occ_q     <= '0;
      stg_vld_q <= 1'b0;
      stg_car_q <= '0;
      stg_tim_q <= '0;
      rd_q      <= '0;
      wr_q      <= '0;
      cnt_q     <= '0;
      head_q    <= '0;
      dup_q     <= 1'b0;
      ghost_q   <= 1'b0;
      ovf_q     <= 1'b0;
      for (int i = 0; i < 16; i++)
        dw_q[i] <= '0;
      for (int i = 0; i < 4; i++)
        mem_q[i] <= '0;
    end else begin
      pre_q     <= pre_d;
      occ_q     <= occ_d;
      stg_vld_q <= stg_vld_d;
      stg_car_q <= stg_car_d;
      stg_tim_q <= stg_tim_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      cnt_q     <= cnt_d;
      head_q    <= head_d;
      dup_q     <= dup_d;
      ghost_q   <= ghost_d;
      ovf_q     <= ovf_d;
      for (int i = 0; i < 16; i++)
        dw_q[i] <= dw_d[i];
      if (push)
        mem_q[wr_q] <= rep;
    end
  end

  // status
  logic [4:0] free_n;

  always_comb begin
    free_n = 5'd16;
    for (int i = 0; i < 16; i++)
      if (occ_q[i]) free_n = free_n - 5'd1;
  end

  assign occupied       = occ_q;
  assign free_cnt       = free_n;
  assign full           = (free_n == 5'd0);
  assign err_dup        = dup_q;
  assign err_ghost      = ghost_q;
  assign fifo_ovf       = ovf_q;
  assign fee.fee_valid  = vld;
  assign fee.fee_car    = head_q.car;
  assign fee.fee_time   = head_q.tim;
  assign fee.fee_amount = head_q.amt;

endmodule

// File: tb/tb_parking_ledger.sv
// Directed bench for parking_ledger: two DUTs (RATE 3 and 255)
// share stimulus; TICK_DIV = 4 on both.
module tb_parking_ledger;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  car;
  logic        enter;
  logic        ex;
  logic        rdy;

  logic [15:0] occ_a, occ_b;
  logic [4:0]  free_a, free_b;
  logic        full_a, full_b;
  logic        dup_a, dup_b;
  logic        gh_a, gh_b;
  logic        ovf_a, ovf_b;

  parking_ledger_if ifa ();
  parking_ledger_if ifb ();

  assign ifa.fee_ready = rdy;
  assign ifb.fee_ready = rdy;

  parking_ledger #(.TICK_DIV(4), .RATE(3)) u_a (
    .clk(clk), .rst(rst), .car_nb(car), .enter(enter), .exit(ex),
    .occupied(occ_a), .free_cnt(free_a), .full(full_a),
    .err_dup(dup_a), .err_ghost(gh_a), .fifo_ovf(ovf_a),
    .fee(ifa.master)
  );

  parking_ledger #(.TICK_DIV(4), .RATE(255)) u_b (
    .clk(clk), .rst(rst), .car_nb(car), .enter(enter), .exit(ex),
    .occupied(occ_b), .free_cnt(free_b), .full(full_b),
    .err_dup(dup_b), .err_ghost(gh_b), .fifo_ovf(ovf_b),
    .fee(ifb.master)
  );

  always #5 clk = ~clk;

  // bench-side prescaler phase and tick count
  int ph = 0;
  int tick_tot = 0;

  always @(posedge clk) begin
    if (!rst) begin
      ph <= 0;
    end else begin
      ph       <= (ph == 3) ? 0 : ph + 1;
      tick_tot <= tick_tot + ((ph == 3) ? 1 : 0);
    end
  end

  typedef struct {
    logic [3:0] c;
    int         t;
  } rep_t;

  typedef struct {
    logic        en;
    logic        ex;
    logic [3:0]  c;
    logic [15:0] occ;
    logic [4:0]  fr;
    logic        fl;
    logic        dup;
    logic        gh;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] occ_m;
  int          ent_t [16];
  rep_t        exp_q [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, expv);
    end
  endtask

  // call at a negedge: set inputs and update the reference model
  task automatic drive(input logic en, input logic x, input logic [3:0] c);
    int t;
    enter = en;
    ex    = x;
    car   = c;
    if (en && !x && !occ_m[c]) begin
      occ_m[c] = 1'b1;
      ent_t[c] = tick_tot + ((ph == 3) ? 1 : 0);
    end else if (x && !en && occ_m[c]) begin
      occ_m[c] = 1'b0;
      t = tick_tot - ent_t[c];
      if (t > 65535) t = 65535;
      exp_q.push_back('{c: c, t: t});
    end
  endtask

  task automatic pulse(input logic en, input logic x, input logic [3:0] c);
    drive(en, x, c);
    @(negedge clk);
    enter = 1'b0;
    ex    = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    int k = 0;
    while (k < n) begin
      if (ph == 3) k++;
      @(negedge clk);
    end
  endtask

  task automatic check_head(input string nm);
    rep_t r;
    int   amt;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: no expected report", nm);
    end else begin
      r   = exp_q.pop_front();
      amt = r.t * 3;
      if (amt > 65535) amt = 65535;
      chk({nm, " valid"},  32'(ifa.fee_valid),  32'd1);
      chk({nm, " car"},    32'(ifa.fee_car),    32'(r.c));
      chk({nm, " time"},   32'(ifa.fee_time),   32'(r.t));
      chk({nm, " amount"}, 32'(ifa.fee_amount), 32'(amt));
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    occ_m = '0;
    exp_q.delete();
    rst = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl [5];
    tbl[0] = '{1'b1, 1'b0, 4'd7, 16'h0080, 5'd15, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 4'd7, 16'h0080, 5'd15, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 4'd9, 16'h0080, 5'd15, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 4'd5, 16'h0080, 5'd15, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 4'd7, 16'h0000, 5'd16, 1'b0, 1'b0, 1'b0};

    enter = 1'b0;
    ex    = 1'b0;
    car   = '0;
    rdy   = 1'b1;
    occ_m = '0;
    do_reset();

    // reset state
    chk("rst occupied", 32'(occ_a), 32'h0);
    chk("rst free_cnt", 32'(free_a), 32'd16);
    chk("rst full", 32'(full_a), 32'd0);
    chk("rst fee_valid", 32'(ifa.fee_valid), 32'd0);
    chk("rst fee_car", 32'(ifa.fee_car), 32'd0);
    chk("rst fee_time", 32'(ifa.fee_time), 32'd0);
    chk("rst fee_amount", 32'(ifa.fee_amount), 32'd0);
    chk("rst errs", 32'({dup_a, gh_a, ovf_a}), 32'd0);

    // basic stay: slot 3, 5 ticks, RATE 3
    pulse(1'b1, 1'b0, 4'd3);
    chk("t1 occupied", 32'(occ_a), 32'h0008);
    chk("t1 free_cnt", 32'(free_a), 32'd15);
    run_ticks(5);
    chk("t1 occupied stay", 32'(occ_a), 32'h0008);
    pulse(1'b0, 1'b1, 4'd3);
    chk("t1 occ after exit", 32'(occ_a), 32'h0);
    chk("t1 free after exit", 32'(free_a), 32'd16);
    chk("t1 valid latency", 32'(ifa.fee_valid), 32'd0);
    @(negedge clk);
    chk("t1 const time", 32'(ifa.fee_time), 32'd5);
    chk("t1 const amount", 32'(ifa.fee_amount), 32'd15);
    check_head("t1 head");
    @(negedge clk);
    chk("t1 drained", 32'(ifa.fee_valid), 32'd0);

    // error vectors
    for (int i = 0; i < 5; i++) begin
      pulse(tbl[i].en, tbl[i].ex, tbl[i].c);
      chk($sformatf("v%0d occupied", i), 32'(occ_a), 32'(tbl[i].occ));
      chk($sformatf("v%0d free", i), 32'(free_a), 32'(tbl[i].fr));
      chk($sformatf("v%0d full", i), 32'(full_a), 32'(tbl[i].fl));
      chk($sformatf("v%0d err_dup", i), 32'(dup_a), 32'(tbl[i].dup));
      chk($sformatf("v%0d err_ghost", i), 32'(gh_a), 32'(tbl[i].gh));
    end
    @(negedge clk);
    check_head("t2 head");
    @(negedge clk);

    // fill all slots
    for (int i = 0; i < 16; i++)
      pulse(1'b1, 1'b0, 4'(i));
    chk("t3 full", 32'(full_a), 32'd1);
    chk("t3 free", 32'(free_a), 32'd0);
    chk("t3 occupied", 32'(occ_a), 32'hFFFF);
    pulse(1'b0, 1'b1, 4'd0);
    chk("t3 full clr", 32'(full_a), 32'd0);
    chk("t3 free one", 32'(free_a), 32'd1);
    @(negedge clk);
    check_head("t3 head");
    @(negedge clk);

    // five back-to-back exits with ready low
    rdy = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b0, 1'b1, 4'(i));
      @(negedge clk);
    end
    enter = 1'b0;
    ex    = 1'b0;
    chk("t4 no ovf yet", 32'(ovf_a), 32'd0);
    @(negedge clk);
    chk("t4 ovf pulse", 32'(ovf_a), 32'd1);
    chk("t4 free", 32'(free_a), 32'd6);
    chk("t4 occupied", 32'(occ_a), 32'(occ_m));
    void'(exp_q.pop_back());
    @(negedge clk);
    chk("t4 ovf clr", 32'(ovf_a), 32'd0);
    chk("t4 hold car", 32'(ifa.fee_car), 32'd1);
    @(negedge clk);
    chk("t4 hold valid", 32'(ifa.fee_valid), 32'd1);
    chk("t4 hold car2", 32'(ifa.fee_car), 32'd1);
    rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_head($sformatf("t4 pop%0d", i));
      @(negedge clk);
    end
    chk("t4 empty", 32'(ifa.fee_valid), 32'd0);
    chk("t4 hold last car", 32'(ifa.fee_car), 32'd4);

    // enter and exit coinciding with ticks
    while (ph != 3) @(negedge clk);
    pulse(1'b1, 1'b0, 4'd2);
    run_ticks(2);
    while (ph != 3) @(negedge clk);
    pulse(1'b0, 1'b1, 4'd2);
    @(negedge clk);
    chk("t5 const time", 32'(ifa.fee_time), 32'd2);
    check_head("t5 head");
    @(negedge clk);

    // saturation on RATE 255, then reset with a pending report
    rdy = 1'b0;
    pulse(1'b1, 1'b0, 4'd4);
    run_ticks(300);
    pulse(1'b0, 1'b1, 4'd4);
    @(negedge clk);
    chk("t6 b valid", 32'(ifb.fee_valid), 32'd1);
    chk("t6 b time", 32'(ifb.fee_time), 32'd300);
    chk("t6 b amount", 32'(ifb.fee_amount), 32'hFFFF);
    chk("t6 a amount", 32'(ifa.fee_amount), 32'd900);
    check_head("t6 head");
    rst = 1'b0;
    @(negedge clk);
    chk("t6 rst valid", 32'(ifb.fee_valid), 32'd0);
    chk("t6 rst occupied", 32'(occ_b), 32'h0);
    chk("t6 rst free", 32'(free_b), 32'd16);
    chk("t6 rst amount", 32'(ifb.fee_amount), 32'd0);
    rst = 1'b1;
    rdy = 1'b1;
    @(negedge clk);
    chk("t6 stays empty", 32'(ifa.fee_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/parking_ledger.md
Name: parking_ledger

Overview:
- Consumes the per-event stream from the switch decoder (car_nb with single-cycle enter/exit pulses) and keeps the slot occupancy map and a per-slot dwell timer.
- On every exit it computes a parking fee and queues a report in a 4-deep output FIFO with a valid/ready handshake toward the display/billing logic.
- Sits between the switch decoder and the display controller.

Parameters:
- TICK_DIV, 100000000, clk cycles per dwell time unit (1 s at 100 MHz); minimum 2.
- RATE, 1, fee units charged per dwell time unit; 1..255.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-low
- car_nb  in  4  slot index of the current event
- enter  in  1  one-cycle pulse: car arrived at slot car_nb
- exit  in  1  one-cycle pulse: car left slot car_nb
- occupied  out  16  bit i = 1 when slot i is occupied
- free_cnt  out  5  number of free slots, 0..16
- full  out  1  1 when free_cnt == 0
- fee_valid  out  1  report available at FIFO head
- fee_ready  in  1  consumer accepts the head report
- fee_car  out  4  slot index of the head report
- fee_time  out  16  dwell time units of the head report
- fee_amount  out  16  fee of the head report
- err_dup  out  1  one-cycle pulse: enter on an occupied slot, or enter and exit both high
- err_ghost  out  1  one-cycle pulse: exit on a free slot
- fifo_ovf  out  1  one-cycle pulse: report dropped because the FIFO was full

Behaviour:
- Reset (rst == 0 at a clk edge) clears the following: prescaler, all 16 dwell counters, occupied, the stage register and the FIFO. Outputs after reset: free_cnt = 16, full = 0, fee_valid = 0, fee_car/fee_time/fee_amount = 0, all error pulses = 0. Reset mid-operation discards any pending and queued reports.
- Prescaler:
  - Counts 0..TICK_DIV-1.
  - tick = 1 for one cycle when the count equals TICK_DIV-1, then the count wraps to 0.
- Dwell counters (16 x 16 bit):
  - On tick, every occupied slot's counter increments, saturating at 0xFFFF.
  - Free slots hold their value.
- Enter (enter = 1, exit = 0) sampled at edge N:
  - Slot free: occupied[car_nb] is set, its counter is cleared, and free_cnt decrements, all visible after edge N. An enter coinciding with tick still leaves the counter at 0.
  - Slot occupied: no state change; err_dup is high for the cycle after edge N.
- Exit (exit = 1, enter = 0) sampled at edge N:
  - Slot occupied:
    - occupied[car_nb] is cleared and free_cnt increments after edge N.
    - The stage register captures {car_nb, counter value before any tick at edge N}.
  - Slot free: no change; err_ghost is high for the cycle after edge N.
- enter and exit both high: the event is ignored and err_dup pulses.
- Fee stage (edge N+1):
  - fee = time x RATE, computed at 24 bits and saturated to 0xFFFF.
  - {car, time, fee} is pushed into the FIFO.
  - With an empty FIFO, fee_valid = 1 after edge N+1 (two-cycle latency from the exit pulse).
- FIFO: depth 4, first-in first-out.
  - The head is presented on fee_car/fee_time/fee_amount whenever fee_valid = 1.
  - Pop happens at an edge where fee_valid && fee_ready.
  - Head fields stay stable while fee_valid && !fee_ready.
  - Push while full without a same-edge pop: the report is dropped, fifo_ovf pulses, and the FIFO contents are unchanged.
  - Push and pop at the same edge while full: both are accepted and the count stays 4.
  - fee_valid = 0 when empty; the head fields then hold their last value.
- Back-to-back exits on consecutive cycles are each captured; the stage register is single-entry but is emptied every cycle.
- free_cnt always equals 16 minus popcount(occupied); full = (free_cnt == 0).

Test Plan:
- Reset, then enter slot 3 and run 5 ticks (TICK_DIV = 4), then exit slot 3 with RATE = 3 and fee_ready = 1 -> occupied = 0x0008 during the stay, free_cnt = 15. Two cycles after exit: fee_valid = 1 with fee_car = 3, fee_time = 5, fee_amount = 15. Afterwards occupied = 0 and free_cnt = 16.
- Enter slot 7 twice; exit slot 9 while slot 9 is free -> err_dup pulses once and err_ghost pulses once. occupied stays 0x0080 and free_cnt stays 15.
- Enter all 16 slots -> full = 1 and free_cnt = 0. Then exit slot 0 -> full = 0 and free_cnt = 1.
- Hold fee_ready = 0 and generate 5 exits -> 4 reports are queued in exit order and fifo_ovf pulses on the 5th. Then hold fee_ready = 1 -> 4 pops in order, after which fee_valid = 0.
- Enter slot 2 in the same cycle as a tick; exit slot 2 in the same cycle as a tick -> after enter, counter = 0. The reported fee_time excludes the coincident exit tick.
- Set RATE = 255 and hold a car for 300 ticks -> fee_time = 300 and fee_amount = 0xFFFF (saturated). Assert reset while a report is pending -> fee_valid = 0 and occupied = 0 on the next cycle.
